// File: rtl/din_event_capture.sv
// din_event_capture: change-driven capture of the digital input port.
// Synchronises the pins, timestamps each change and streams it from a FIFO.
module din_event_capture #(
   parameter int WIDTH       = 8,
   parameter int TS_WIDTH    = 24,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic [WIDTH-1:0]              i_port,
   input  logic                          i_enable,
   input  logic                          i_clear_overflow,
   input  logic                          i_ready,
   output logic [TS_WIDTH+WIDTH-1:0]     o_data,
   output logic                          o_valid,
   output logic                          o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = TS_WIDTH + WIDTH;
   localparam int PW = $clog2(SYNC_STAGES + 2);
   localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

   logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]    sync_out;
   logic [WIDTH-1:0]    prev_q;
   logic [TS_WIDTH-1:0] ts_q;
   logic [PW-1:0]       prime_q;
   logic                primed;

   logic [DW-1:0]       mem_q [FIFO_DEPTH];
   logic [AW:0]         wr_ptr_q;
   logic [AW:0]         rd_ptr_q;
   logic [LW-1:0]       level_q;
   logic                ovf_q;

   logic                empty;
   logic                full;
   logic                change;
   logic                pop;
   logic                push;
   logic                drop;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign primed   = (prime_q == PRIME_DONE);

   // Metastability chain for the asynchronous pins.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= i_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Previous synchronised state tracks the pins even while disabled,
   // so re-enabling never reports a stale difference.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= sync_out;
      end
   end

   // Free-running timestamp, wraps naturally at the counter width.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_WIDTH'(1);
      end
   end

   // Hold off detection until the chain and prev hold real pin values,
   // so pins already high at reset release do not look like an edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prime_q <= '0;
      end else if (!primed) begin
         prime_q <= prime_q + PW'(1);
      end
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Change detect and FIFO push/pop/drop decisions.
   always_comb begin
      change = 1'b0;
      pop    = 1'b0;
      push   = 1'b0;
      drop   = 1'b0;
      change = i_enable && primed && (sync_out != prev_q);
      pop    = !empty && i_ready;
      push   = change && (!full || pop);
      drop   = change && full && !pop;
   end

   // Event storage; entries need no reset since pointers gate them.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {ts_q, sync_out};
      end
   end

   // Write and read pointers with wrap bit.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   // Registered occupancy count.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         level_q <= '0;
      end else begin
         unique case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Sticky overflow; a new drop beats a simultaneous clear.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (i_clear_overflow) begin
         ovf_q <= 1'b0;
      end
   end

   assign o_valid    = !empty;
   assign o_data     = o_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   assign o_overflow = ovf_q;
   assign o_level    = level_q;

endmodule
